kanagawa_hal_sdp_ram_tile_be: RTL and testbench
===============================================

// Module: kanagawa_hal_sdp_ram_tile_be
// PURPOSE
//   Simulation-model simple dual-port RAM tile: one write port, one read port, one clock.
//   Adds per-byte write enables, a configurable read pipeline with a valid strobe,
//   selectable read/write collision semantics and a zero-fill sequencer after reset.
//   It is a tiling primitive: memory generators stitch several tiles to build a large memory.
// PARAMETERS
//   WIDTH          32   data width in bits (>=1)
//   DEPTH          32   number of words (>=2; need not be a power of two)
//   BYTE_WIDTH      8   bits per write-enable lane; NUM_LANES = ceil(WIDTH/BYTE_WIDTH)
//   READ_LATENCY    2   cycles from rd_en_in sampled to rd_valid_out; legal 1..3
//   BYPASS_RW       1   1 = same-cycle same-address read returns new data; 0 = returns old data
//   INIT_ON_RESET   1   1 = zero-fill the array after reset; 0 = contents are X until written
//   ADDR_WIDTH   $clog2(DEPTH)  address width (derived)
// PORTS
//   clk            in   1           clock; all logic is on the rising edge
//   rst            in   1           asynchronous, active-high reset
//   init_busy_out  out  1           high while the zero-fill runs; ports are ignored
//   wr_en_in       in   1           write strobe
//   wr_addr_in     in   ADDR_WIDTH  write address
//   wr_data_in     in   WIDTH       write data
//   wr_be_in       in   NUM_LANES   lane enables; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//   rd_en_in       in   1           read strobe
//   rd_addr_in     in   ADDR_WIDTH  read address
//   rd_data_out    out  WIDTH       read data; holds its last value while rd_valid_out=0
//   rd_valid_out   out  1           one-cycle pulse per accepted read
// BEHAVIOUR
//   Reset (async assert, sync release): rd_valid_out=0, rd_data_out=0, read pipe cleared,
//     init_busy_out=INIT_ON_RESET. Reset does not clear the array itself.
//   FSM: INIT -> READY.
//     - INIT_ON_RESET=1: after reset releases, INIT writes 0 to address 0..DEPTH-1, one
//       address per cycle. init_busy_out stays high for exactly DEPTH cycles, then the FSM
//       enters READY. INIT_ON_RESET=0: the FSM enters READY directly.
//     - During INIT, wr_en_in and rd_en_in are ignored and no rd_valid_out pulse is issued.
//     - If reset asserts during INIT, the fill restarts from address 0 after release.
//   Write: in READY, wr_en_in=1 updates only the enabled lanes at the next edge. The last lane
//     may be partial (WIDTH % BYTE_WIDTH). wr_be_in=0 with wr_en_in=1 leaves the word unchanged.
//   Read: a read sampled at edge t drives rd_valid_out=1 and rd_data_out in the cycle after edge
//     t+READY_LATENCY-1, so the data is visible READ_LATENCY cycles after the request.
//     - Throughput is one read per cycle with no bubbles.
//     - Data is captured at request time. Writes accepted after the read edge do not alter the
//       data of that read.
//   Collision (same cycle, wr_en_in & rd_en_in, equal addresses):
//     - BYPASS_RW=1: returned word = enabled lanes from wr_data_in, other lanes from the old word.
//     - BYPASS_RW=0: returned word = old word in full.
//   Write at edge t, then a read of the same address at edge t+1: returns the new data
//     in both modes.
//   Out-of-range address (>= DEPTH): the write is dropped. The read still pulses
//     rd_valid_out, with data 0.
//   Simultaneous reads and writes to different addresses are independent.
//   Parameter checks: an elaboration-time $error if READ_LATENCY is outside 1..3 or DEPTH < 2.
//   The block is simulation-only: compiling it without SIMULATION defined is an error.
// TESTING
//   1. INIT: release reset. Expect init_busy_out high for 32 cycles. Then read addresses 0..31:
//      each returns 0 with rd_valid_out at +2 cycles.
//   2. Byte enables: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
//      A read of addr 5 returns 0xAA22CC44.
//   3. Collision: addr 7 holds 0x0; same cycle, write 0xDEADBEEF with be=4'b0011 and read addr 7.
//      BYPASS_RW=1 returns 0x0000BEEF; BYPASS_RW=0 returns 0x00000000.
//   4. Streaming: 32 back-to-back reads at READ_LATENCY=1, 2 and 3. Expect 32 consecutive
//      valid pulses in order, the first at exactly +L cycles; data holds after the last pulse.
//   5. Reset mid-INIT: assert rst at fill cycle 10 and release. The full 32-cycle fill repeats,
//      and a read issued during INIT produces no rd_valid_out.
//   6. DEPTH=24: write addr 30 is dropped, and a read of addr 30 returns 0 with valid.
//      Addresses 0..23 are unaffected.

Source files
------------

// File: rtl/kanagawa_hal_sdp_ram_tile_be.sv
// Simple dual-port RAM tile: byte-lane writes, pipelined reads with valid,
// selectable collision bypass and a zero-fill sequencer after reset.
module kanagawa_hal_sdp_ram_tile_be #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 2,
  parameter bit BYPASS_RW      = 1'b1,
  parameter bit INIT_ON_RESET  = 1'b1,
  localparam int NUM_LANES     = (WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy_out,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [WIDTH-1:0]      wr_data_in,
  input  logic [NUM_LANES-1:0]  wr_be_in,
  input  logic                  rd_en_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  output logic [WIDTH-1:0]      rd_data_out,
  output logic                  rd_valid_out
);

`ifndef SIMULATION
  if (1) begin : g_sim_only
    $error("simulation-only model: define SIMULATION");
  end
`endif

  if (READ_LATENCY < 1 || READ_LATENCY > 3 || DEPTH < 2) begin : g_bad_param
    $error("illegal READ_LATENCY or DEPTH");
  end

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic [ADDR_WIDTH-1:0] w_init_addr_nxt;
  logic                  w_ready;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_collide;
  logic [WIDTH-1:0]      w_mask;
  logic [WIDTH-1:0]      w_wr_old;
  logic [WIDTH-1:0]      w_wr_word;
  logic [WIDTH-1:0]      w_rd_old;
  logic [WIDTH-1:0]      w_rd_word;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic                  r_pv  [READ_LATENCY];
  logic [WIDTH-1:0]      r_pd  [READ_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT_ON_RESET ? S_INIT : S_READY;
      r_init_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_addr <= w_init_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    unique case (r_state)
      S_INIT: begin
        w_init_addr_nxt = r_init_addr + 1'b1;
        if (r_init_addr == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_nxt     = S_READY;
          w_init_addr_nxt = '0;
        end
      end
      S_READY: begin
        w_state_nxt = S_READY;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign w_ready       = (r_state == S_READY);
  assign init_busy_out = !w_ready;

  // Power-of-two depths cannot address past the end of the array.
  if ((1 << ADDR_WIDTH) == DEPTH) begin : g_pow2
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_npow2
    assign w_wr_in_range = wr_addr_in < ADDR_WIDTH'(DEPTH);
    assign w_rd_in_range = rd_addr_in < ADDR_WIDTH'(DEPTH);
  end

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_mask[b] = wr_be_in[b / BYTE_WIDTH];
    end
  end

  assign w_wr_ok   = w_ready & wr_en_in & w_wr_in_range;
  assign w_rd_ok   = w_ready & rd_en_in;
  assign w_wr_old  = r_mem[wr_addr_in];
  assign w_wr_word = (w_wr_old & ~w_mask) | (wr_data_in & w_mask);
  assign w_rd_old  = w_rd_in_range ? r_mem[rd_addr_in] : '0;
  assign w_collide = w_wr_ok & (wr_addr_in == rd_addr_in);
  assign w_rd_word = (BYPASS_RW && w_collide) ? w_wr_word : w_rd_old;

  // Array has no reset: contents survive rst apart from the zero-fill.
  always_ff @(posedge clk) begin
    if (!rst && !w_ready) begin
      r_mem[r_init_addr] <= '0;
    end else if (!rst && w_wr_ok) begin
      r_mem[wr_addr_in] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_ok;
      if (w_rd_ok) begin
        r_pd[0] <= w_rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
        end
      end
    end
  end

  assign rd_valid_out = r_pv[READ_LATENCY-1];
  assign rd_data_out  = r_pd[READ_LATENCY-1];

endmodule

// File: tb/tb_kanagawa_hal_sdp_ram_tile_be.sv
// Directed bench for the RAM tile: several parameterisations share one
// stimulus bus and each scenario task checks the instances it targets.
module tb_kanagawa_hal_sdp_ram_tile_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [4:0]  rd_addr;

  logic        b_dut, b_l1, b_l3, b_nb, b_24;
  logic        v_dut, v_l1, v_l3, v_nb, v_24;
  logic [31:0] d_dut, d_l1, d_l3, d_nb, d_24;

  int n_chk  = 0;
  int n_fail = 0;

  logic        vs  [4];
  logic [31:0] ds  [4];
  int          lat [4] = '{1, 2, 3, 2};

  always #5 clk = ~clk;

  always_comb begin
    vs[0] = v_l1;  ds[0] = d_l1;
    vs[1] = v_dut; ds[1] = d_dut;
    vs[2] = v_l3;  ds[2] = d_l3;
    vs[3] = v_24;  ds[3] = d_24;
  end

  kanagawa_hal_sdp_ram_tile_be u_dut (
    .clk(clk), .rst(rst), .init_busy_out(b_dut),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_data_in(wr_data), .wr_be_in(wr_be),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(d_dut), .rd_valid_out(v_dut)
  );

  kanagawa_hal_sdp_ram_tile_be #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .init_busy_out(b_l1),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_data_in(wr_data), .wr_be_in(wr_be),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(d_l1), .rd_valid_out(v_l1)
  );

  kanagawa_hal_sdp_ram_tile_be #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .init_busy_out(b_l3),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_data_in(wr_data), .wr_be_in(wr_be),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(d_l3), .rd_valid_out(v_l3)
  );

  kanagawa_hal_sdp_ram_tile_be #(.BYPASS_RW(1'b0)) u_nb (
    .clk(clk), .rst(rst), .init_busy_out(b_nb),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_data_in(wr_data), .wr_be_in(wr_be),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(d_nb), .rd_valid_out(v_nb)
  );

  kanagawa_hal_sdp_ram_tile_be #(.DEPTH(24)) u_d24 (
    .clk(clk), .rst(rst), .init_busy_out(b_24),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_data_in(wr_data), .wr_be_in(wr_be),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(d_24), .rd_valid_out(v_24)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    step();
    wr_en   = 1'b0;
  endtask

  // Leaves the bench just after the edge that sampled the read.
  task automatic rd_issue(input logic [4:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
  endtask

  task automatic count_busy(input bit do_reads, output int c_main,
                            output int c_24, output int v_seen);
    c_main = 0;
    c_24   = 0;
    v_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (b_dut) c_main++;
      if (b_24) c_24++;
      if (v_dut | v_l1 | v_l3 | v_nb | v_24) v_seen++;
      rd_en   = do_reads && (i < 5);
      rd_addr = 5'(i);
      step();
    end
    rd_en = 1'b0;
  endtask

  task automatic stream_check(input string nm, input logic [31:0] exp [32],
                              input bit with24);
    int k;
    for (int j = 0; j < 36; j++) begin
      rd_en   = (j < 32);
      rd_addr = 5'(j);
      step();
      for (int n = 0; n < 4; n++) begin
        if (n == 3 && !with24) continue;
        k = j - lat[n] + 1;
        n_chk++;
        if (k < 0) begin
          if (vs[n] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early inst%0d cyc%0d: valid=%b, required 0",
                     nm, n, j, vs[n]);
          end
        end else if (k < 32) begin
          if ({vs[n], ds[n]} !== {1'b1, exp[k]}) begin
            n_fail++;
            $display("FAIL %s inst%0d rd%0d: valid=%b data=%h, required 1 %h",
                     nm, n, k, vs[n], ds[n], exp[k]);
          end
        end else begin
          if ({vs[n], ds[n]} !== {1'b0, exp[31]}) begin
            n_fail++;
            $display("FAIL %s hold inst%0d cyc%0d: valid=%b data=%h, required 0 %h",
                     nm, n, j, vs[n], ds[n], exp[31]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    int cm, c24, vs_n;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    repeat (3) step();
    n_chk++;
    if ({b_dut, v_dut, d_dut} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b data=%h, required 1 0 0",
               b_dut, v_dut, d_dut);
    end
    rst = 1'b0;
    count_busy(1'b0, cm, c24, vs_n);
    n_chk++;
    if (cm !== 32) begin
      n_fail++;
      $display("FAIL init_busy_len: %0d cycles, required 32", cm);
    end
    n_chk++;
    if (c24 !== 24) begin
      n_fail++;
      $display("FAIL init_busy_len_d24: %0d cycles, required 24", c24);
    end
  endtask

  task automatic test_init_read();
    logic [31:0] z [32];
    for (int i = 0; i < 32; i++) z[i] = 32'h0;
    idle(4);
    stream_check("init_zero", z, 1'b1);
  endtask

  task automatic test_byte_enable();
    idle(4);
    wr(5'd5, 32'hAABBCCDD, 4'b1111);
    wr(5'd5, 32'h11223344, 4'b0101);
    rd_issue(5'd5);
    n_chk++;
    if (v_dut !== 1'b0) begin
      n_fail++;
      $display("FAIL be_latency: valid=%b at +1, required 0", v_dut);
    end
    step();
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'hAA22CC44}) begin
      n_fail++;
      $display("FAIL be_merge: valid=%b data=%h, required 1 aa22cc44",
               v_dut, d_dut);
    end
    wr(5'd5, 32'hFFFFFFFF, 4'b0000);
    rd_issue(5'd5);
    step();
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'hAA22CC44}) begin
      n_fail++;
      $display("FAIL be_zero: valid=%b data=%h, required 1 aa22cc44",
               v_dut, d_dut);
    end
  endtask

  task automatic test_collision();
    idle(2);
    wr(5'd7, 32'h0, 4'b1111);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 5'd7;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'h0000BEEF}) begin
      n_fail++;
      $display("FAIL coll_bypass: valid=%b data=%h, required 1 0000beef",
               v_dut, d_dut);
    end
    n_chk++;
    if ({v_nb, d_nb} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL coll_old: valid=%b data=%h, required 1 00000000",
               v_nb, d_nb);
    end
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88888888; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 5'd7;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    n_chk++;
    if ({v_nb, d_nb} !== {1'b1, 32'h0000BEEF}) begin
      n_fail++;
      $display("FAIL coll_after_old: valid=%b data=%h, required 1 0000beef",
               v_nb, d_nb);
    end
    rd_issue(5'd8);
    step();
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'h88888888}) begin
      n_fail++;
      $display("FAIL indep_write: valid=%b data=%h, required 1 88888888",
               v_dut, d_dut);
    end
  endtask

  task automatic test_capture();
    idle(2);
    wr(5'd9, 32'h11111111, 4'b1111);
    rd_issue(5'd9);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22222222; wr_be = 4'b1111;
    step();
    wr_en = 1'b0;
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'h11111111}) begin
      n_fail++;
      $display("FAIL capture_l2: valid=%b data=%h, required 1 11111111",
               v_dut, d_dut);
    end
    step();
    n_chk++;
    if ({v_l3, d_l3} !== {1'b1, 32'h11111111}) begin
      n_fail++;
      $display("FAIL capture_l3: valid=%b data=%h, required 1 11111111",
               v_l3, d_l3);
    end
    rd_issue(5'd9);
    step();
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'h22222222}) begin
      n_fail++;
      $display("FAIL capture_new: valid=%b data=%h, required 1 22222222",
               v_dut, d_dut);
    end
  endtask

  task automatic test_out_of_range();
    idle(3);
    wr(5'd23, 32'h23232323, 4'b1111);
    wr(5'd30, 32'h12345678, 4'b1111);
    rd_issue(5'd30);
    step();
    n_chk++;
    if ({v_24, d_24} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL oob_read: valid=%b data=%h, required 1 00000000",
               v_24, d_24);
    end
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'h12345678}) begin
      n_fail++;
      $display("FAIL inrange_30: valid=%b data=%h, required 1 12345678",
               v_dut, d_dut);
    end
    rd_issue(5'd23);
    step();
    n_chk++;
    if ({v_24, d_24} !== {1'b1, 32'h23232323}) begin
      n_fail++;
      $display("FAIL oob_23: valid=%b data=%h, required 1 23232323",
               v_24, d_24);
    end
    rd_issue(5'd6);
    step();
    n_chk++;
    if ({v_24, d_24} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL oob_6: valid=%b data=%h, required 1 00000000",
               v_24, d_24);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [32];
    idle(3);
    for (int i = 0; i < 32; i++) begin
      pat[i] = 32'hC0DE0000 + 32'(i) * 32'h00000111;
      wr(5'(i), pat[i], 4'b1111);
    end
    idle(1);
    stream_check("stream", pat, 1'b0);
  endtask

  task automatic test_reset_mid_init();
    int cm, c24, vs_n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    n_chk++;
    if (b_dut !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b, required 1", b_dut);
    end
    rst = 1'b1;
    step();
    n_chk++;
    if ({b_dut, v_dut, d_dut} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_state: busy=%b valid=%b data=%h, required 1 0 0",
               b_dut, v_dut, d_dut);
    end
    rst = 1'b0;
    count_busy(1'b1, cm, c24, vs_n);
    n_chk++;
    if (cm !== 32) begin
      n_fail++;
      $display("FAIL refill_len: %0d cycles, required 32", cm);
    end
    n_chk++;
    if (vs_n !== 0) begin
      n_fail++;
      $display("FAIL init_read_ignored: %0d valid cycles, required 0", vs_n);
    end
    rd_issue(5'd5);
    step();
    n_chk++;
    if ({v_dut, d_dut} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL refill_zero: valid=%b data=%h, required 1 00000000",
               v_dut, d_dut);
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_byte_enable();
    test_collision();
    test_capture();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
